captouch_pad_emulator: RTL and testbench

Responder side of the capacitive-touch button scan: emulates up to NUM_PADS touch pads on a board that has no real pads. It watches each open-drain pad line being discharged (driven low) by a scanning controller and released. For a pad whose TOUCH input is asserted, it holds the line low for TOUCH_DELAY cycles after release, mimicking the slow RC rise of a touched pad. It sits between the board pad pins, which carry the external pull-ups, and a test-stimulus source or host register bank driving TOUCH.

---
 rtl/captouch_pkg.sv | 20 ++
 rtl/captouch_pad_fsm.sv | 119 +++++++++++
 rtl/captouch_pad_emulator.sv | 70 +++++++
 tb/tb_captouch_pad_emulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/captouch_pkg.sv
// Shared definitions for the capacitive-touch pad emulator: per-pad FSM
// state encoding and a constant-width helper.
package captouch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISCHARGE = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RECOVER   = 2'd3
  } pad_state_e;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/captouch_pad_fsm.sv
// One emulated pad: input synchronizers, discharge/hold/recover FSM and the
// registered open-drain drive enable. scan_accept is combinational; the top registers it.
module captouch_pad_fsm
  import captouch_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_DISCHARGE = 16,
  parameter int TOUCH_DELAY   = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pad_in,
  input  logic touch_in,
  output logic scan_accept,
  output logic touch_value,
  output logic drive_en
);

  localparam int RECOVER_CYC = SYNC_STAGES + 1;
  localparam int HC_MAX      = (TOUCH_DELAY > RECOVER_CYC) ? TOUCH_DELAY : RECOVER_CYC;
  localparam int LC_W        = clog2(MIN_DISCHARGE + 1);
  localparam int HC_W        = clog2(HC_MAX + 1);

  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(MIN_DISCHARGE);
  localparam logic [HC_W-1:0] HC_HOLD = HC_W'(TOUCH_DELAY);
  localparam logic [HC_W-1:0] HC_REC  = HC_W'(RECOVER_CYC);

  logic [SYNC_STAGES-1:0] pad_sync_q, pad_sync_d;
  logic [SYNC_STAGES-1:0] touch_sync_q, touch_sync_d;
  pad_state_e             state_q, state_d;
  logic [LC_W-1:0]        lc_q, lc_d;
  logic [HC_W-1:0]        hc_q, hc_d;
  logic                   touch_lat_q, touch_lat_d;
  logic                   drive_q, drive_d;
  logic                   s, touch_s;

  assign s       = pad_sync_q[SYNC_STAGES-1];
  assign touch_s = touch_sync_q[SYNC_STAGES-1];

  always_comb begin
    pad_sync_d   = {pad_sync_q[SYNC_STAGES-2:0], pad_in};
    touch_sync_d = {touch_sync_q[SYNC_STAGES-2:0], touch_in};
    state_d      = state_q;
    lc_d         = lc_q;
    hc_d         = hc_q;
    touch_lat_d  = touch_lat_q;
    scan_accept  = 1'b0;
    touch_value  = touch_lat_q;

    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_DISCHARGE;
          lc_d    = LC_W'(1);
        end
      end
      ST_DISCHARGE: begin
        if (!s) begin
          if (lc_q != LC_MAX) lc_d = lc_q + 1'b1;
        end else begin
          lc_d = '0;
          if (lc_q == LC_MAX) begin
            scan_accept = 1'b1;
            hc_d        = HC_W'(1);
            state_d     = touch_lat_q ? ST_HOLD : ST_RECOVER;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (hc_q == HC_HOLD) begin
          state_d = ST_RECOVER;
          hc_d    = HC_W'(1);
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        // Our own low drive is still in the synchronizer; ignore s until it drains.
        if (hc_q == HC_REC) begin
          state_d = ST_IDLE;
          hc_d    = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Touch is sampled once, on the cycle the low count first saturates.
    if ((lc_d == LC_MAX) && (lc_q != LC_MAX)) touch_lat_d = touch_s;

    drive_d = (state_q == ST_HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pad_sync_q   <= '1;
      touch_sync_q <= '0;
      state_q      <= ST_IDLE;
      lc_q         <= '0;
      hc_q         <= '0;
      touch_lat_q  <= 1'b0;
      drive_q      <= 1'b0;
    end else begin
      pad_sync_q   <= pad_sync_d;
      touch_sync_q <= touch_sync_d;
      state_q      <= state_d;
      lc_q         <= lc_d;
      hc_q         <= hc_d;
      touch_lat_q  <= touch_lat_d;
      drive_q      <= drive_d;
    end
  end

  assign drive_en = drive_q;

endmodule

// File: rtl/captouch_pad_emulator.sv
// Emulates NUM_PADS capacitive-touch pads on open-drain lines: one FSM per pad,
// registered scan/touch outputs and a wrapping scan counter for pad 0.
module captouch_pad_emulator
  import captouch_pkg::*;
#(
  parameter int NUM_PADS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_DISCHARGE = 16,
  parameter int TOUCH_DELAY   = 8,
  parameter int CNT_W         = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  inout  wire  [NUM_PADS-1:0] PAD,
  input  logic [NUM_PADS-1:0] TOUCH,
  output logic [NUM_PADS-1:0] SCAN_DONE,
  output logic [NUM_PADS-1:0] TOUCH_REPORTED,
  output logic [CNT_W-1:0]    SCAN_COUNT
);

  logic [NUM_PADS-1:0] scan_accept;
  logic [NUM_PADS-1:0] touch_value;
  logic [NUM_PADS-1:0] drive_en;

  logic [NUM_PADS-1:0] scan_done_q, scan_done_d;
  logic [NUM_PADS-1:0] touch_rep_q, touch_rep_d;
  logic [CNT_W-1:0]    count_q, count_d;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    captouch_pad_fsm #(
      .SYNC_STAGES  (SYNC_STAGES),
      .MIN_DISCHARGE(MIN_DISCHARGE),
      .TOUCH_DELAY  (TOUCH_DELAY)
    ) u_fsm (
      .CLK        (CLK),
      .RESET      (RESET),
      .pad_in     (PAD[i]),
      .touch_in   (TOUCH[i]),
      .scan_accept(scan_accept[i]),
      .touch_value(touch_value[i]),
      .drive_en   (drive_en[i])
    );

    // Open-drain: only ever pull low or float.
    assign PAD[i] = drive_en[i] ? 1'b0 : 1'bz;
  end

  always_comb begin
    scan_done_d = scan_accept;
    touch_rep_d = (scan_accept & touch_value) | (~scan_accept & touch_rep_q);
    count_d     = count_q + CNT_W'(scan_done_q[0]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_done_q <= '0;
      touch_rep_q <= '0;
      count_q     <= '0;
    end else begin
      scan_done_q <= scan_done_d;
      touch_rep_q <= touch_rep_d;
      count_q     <= count_d;
    end
  end

  assign SCAN_DONE      = scan_done_q;
  assign TOUCH_REPORTED = touch_rep_q;
  assign SCAN_COUNT     = count_q;

endmodule

// File: tb/tb_captouch_pad_emulator.sv
// Directed bench: pull-ups plus a controller driver on two emulators (default
// counter width, and a 4-bit counter for the wrap case) sharing the controller.
module tb_captouch_pad_emulator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  TOUCH;
  logic [3:0]  touch2;
  logic [3:0]  ctl_low;
  wire  [3:0]  pad_w;
  wire  [3:0]  pad2_w;
  logic [3:0]  sd, tr, sd2, tr2;
  logic [15:0] cnt;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] last_sd, last_sd2;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 4; i++) begin : g_board
    pullup (pad_w[i]);
    pullup (pad2_w[i]);
    assign pad_w[i]  = ctl_low[i] ? 1'b0 : 1'bz;
    assign pad2_w[i] = ctl_low[i] ? 1'b0 : 1'bz;
  end

  captouch_pad_emulator dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PAD           (pad_w),
    .TOUCH         (TOUCH),
    .SCAN_DONE     (sd),
    .TOUCH_REPORTED(tr),
    .SCAN_COUNT    (cnt)
  );

  captouch_pad_emulator #(.CNT_W(4)) dut_w4 (
    .CLK           (CLK),
    .RESET         (RESET),
    .PAD           (pad2_w),
    .TOUCH         (touch2),
    .SCAN_DONE     (sd2),
    .TOUCH_REPORTED(tr2),
    .SCAN_COUNT    (cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive pads in m low for nlow cycles, release, then watch 20 cycles.
  // done_off: cycles after release of the first SCAN_DONE on m; low_mask bit k:
  // pad pi read low k cycles after release.
  task automatic scan(input logic [3:0] m, input int pi, input int nlow, input int touch_at,
                      output int done_off, output int ndone, output logic [31:0] low_mask);
    ctl_low = ctl_low | m;
    for (int k = 1; k <= nlow; k++) begin
      step();
      if (k == touch_at) TOUCH[pi] = 1'b1;
    end
    ctl_low  = ctl_low & ~m;
    done_off = -1;
    ndone    = 0;
    low_mask = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((sd & m) != 4'h0) begin
        ndone++;
        if (done_off < 0) begin
          done_off = k;
          last_sd  = sd;
          last_sd2 = sd2;
        end
      end
      if (pad_w[pi] === 1'b0) low_mask[k] = 1'b1;
    end
  endtask

  int          off, nd, total;
  logic [31:0] lm;

  initial begin
    RESET   = 1'b1;
    TOUCH   = 4'h0;
    touch2  = 4'h0;
    ctl_low = 4'h0;
    last_sd = 4'h0;
    last_sd2 = 4'h0;
    repeat (3) step();
    chk("rst_done", 32'(sd), 32'h0);
    chk("rst_trep", 32'(tr), 32'h0);
    chk("rst_count", 32'(cnt), 32'h0);
    chk("rst_pads", 32'(pad_w), 32'hF);
    RESET = 1'b0;
    repeat (2) step();

    // Untouched scan on pad 0
    scan(4'b0001, 0, 20, -1, off, nd, lm);
    chk("untouched_done_off", 32'(off), 32'd3);
    chk("untouched_ndone", 32'(nd), 32'd1);
    chk("untouched_low", lm, 32'h0);
    chk("untouched_trep", 32'(tr[0]), 32'h0);
    chk("untouched_count", 32'(cnt), 32'd1);
    chk("untouched_count_w4", 32'(cnt2), 32'd1);

    // Touched scan on pad 1: held low exactly t+4..t+11
    TOUCH[1] = 1'b1;
    repeat (4) step();
    scan(4'b0010, 1, 20, -1, off, nd, lm);
    chk("touched_done_off", 32'(off), 32'd3);
    chk("touched_low", lm, 32'h0000_0FF0);
    chk("touched_trep", 32'(tr), 32'b0010);
    chk("touched_count", 32'(cnt), 32'd1);

    // Glitches and the MIN_DISCHARGE boundary on pad 2
    scan(4'b0100, 2, 10, -1, off, nd, lm);
    chk("glitch10_ndone", 32'(nd), 32'd0);
    chk("glitch10_low", lm, 32'h0);
    scan(4'b0100, 2, 15, -1, off, nd, lm);
    chk("glitch15_ndone", 32'(nd), 32'd0);
    scan(4'b0100, 2, 16, -1, off, nd, lm);
    chk("min16_done_off", 32'(off), 32'd3);
    chk("min16_ndone", 32'(nd), 32'd1);
    chk("min16_low", lm, 32'h0);

    // TOUCH[3] rises 5 cycles after the low count saturates: that scan is not held
    scan(4'b1000, 3, 30, 23, off, nd, lm);
    chk("midtouch_done_off", 32'(off), 32'd3);
    chk("midtouch_low", lm, 32'h0);
    chk("midtouch_trep3", 32'(tr[3]), 32'h0);
    scan(4'b1000, 3, 20, -1, off, nd, lm);
    chk("nexttouch_low", lm, 32'h0000_0FF0);
    chk("nexttouch_trep", 32'(tr), 32'b1010);

    // Reset three cycles into a hold on pad 1
    ctl_low[1] = 1'b1;
    repeat (20) step();
    ctl_low[1] = 1'b0;
    repeat (6) step();
    chk("hold_before_rst", 32'(pad_w[1]), 32'h0);
    RESET = 1'b1;
    step();
    chk("rst_hold_pad", 32'(pad_w[1]), 32'h1);
    chk("rst_hold_done", 32'(sd), 32'h0);
    chk("rst_hold_trep", 32'(tr), 32'h0);
    chk("rst_hold_count", 32'(cnt), 32'h0);
    chk("rst_hold_count_w4", 32'(cnt2), 32'h0);
    RESET = 1'b0;
    repeat (3) step();
    scan(4'b0001, 0, 20, -1, off, nd, lm);
    chk("postrst_done_off", 32'(off), 32'd3);
    chk("postrst_low", lm, 32'h0);
    chk("postrst_count", 32'(cnt), 32'd1);

    // Fifteen more pad-0 scans: 4-bit counter wraps to 0
    total = 0;
    for (int n = 0; n < 15; n++) begin
      scan(4'b0001, 0, 20, -1, off, nd, lm);
      total += nd;
    end
    chk("wrap_pulses", 32'(total), 32'd15);
    chk("wrap_count16", 32'(cnt), 32'd16);
    chk("wrap_count_w4", 32'(cnt2), 32'd0);

    // All four pads scanned together pulse SCAN_DONE in the same cycle
    scan(4'b1111, 0, 20, -1, off, nd, lm);
    chk("all_done_off", 32'(off), 32'd3);
    chk("all_done", 32'(last_sd), 32'hF);
    chk("all_done_w4", 32'(last_sd2), 32'hF);
    chk("all_trep", 32'(tr), 32'b1010);
    chk("all_trep_w4", 32'(tr2), 32'h0);
    chk("all_count_w4", 32'(cnt2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
